gun_fire_arbiter: RTL and testbench

GUN_FIRE_ARBITER -- requirements
Module: gun_fire_arbiter

---
 rtl/gun_fire_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gun_fire_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/gun_fire_arbiter.sv
// Purpose : round-robin arbiter granting one of three operator consoles control of the gun.
// Latency : grant, fire_command and firing_mode change one sysclk edge after the deciding inputs.
// Backpressure: none; a console keeps its request asserted until served, and losers simply wait.
//
// Ports:
//   sysclk        clock, all state on rising edge
//   reboot_n      asynchronous active-low reset
//   req[2:0]      per-console fire request
//   mode[2:0]     per-console firing mode (0 single, 1 auto)
//   gun_state[2:0] gun status: 000 idle, 001 single, 010 auto, 011 reload, 100 overheat,
//                 101 downfall; other codes behave as 000
//   grant[2:0]    one-hot owner of the gun, 000 when nobody owns it
//   fire_command  fire strobe to the gun
//   firing_mode   mode of the owning console, captured at grant time
//   busy          FSM is not in IDLE
//   halted        FSM is in HALT (leave only by reset)
module gun_fire_arbiter #(
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic       sysclk,
    input  logic       reboot_n,
    input  logic [2:0] req,
    input  logic [2:0] mode,
    input  logic [2:0] gun_state,
    output logic [2:0] grant,
    output logic       fire_command,
    output logic       firing_mode,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2,
        HALT = 2'd3
    } state_t;

    // Last hold_cnt value before FIRE is forced to give the gun up.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    // The IDLE cycle that follows GAP is itself a dead cycle, so GAP only
    // covers the remaining GAP_CYCLES-1 cycles (at least one). With requests
    // waiting this gives exactly GAP_CYCLES cycles of grant=000 between owners.
    localparam logic [7:0] GAP_LAST  = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 2) : 8'd0;

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic       fire_command_q, fire_command_d;
    logic       firing_mode_q, firing_mode_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [1:0] last_ptr_q, last_ptr_d;
    // Goes high on the first edge after reset release; holds off the first
    // grant by one edge so reset release and arbitration never coincide.
    logic       armed_q, armed_d;

    logic       gs_halt;
    logic       gs_block;
    logic       win_vld;
    logic [1:0] win_idx;

    assign gs_halt  = (gun_state == 3'b101);
    assign gs_block = (gun_state == 3'b011) || (gun_state == 3'b100);

    // Round-robin search starting at the console after last_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (int'(last_ptr_q) + k) % 3;
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win_idx = 2'(j);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        fire_command_d = fire_command_q;
        firing_mode_d  = firing_mode_q;
        hold_cnt_d     = hold_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        last_ptr_d     = last_ptr_q;
        armed_d        = 1'b1;

        case (state_q)
            IDLE: begin
                if (gs_halt) begin
                    state_d        = HALT;
                    grant_d        = 3'b000;
                    fire_command_d = 1'b0;
                end else if (armed_q && win_vld && !gs_block) begin
                    state_d        = FIRE;
                    grant_d        = 3'b001 << win_idx;
                    fire_command_d = 1'b1;
                    firing_mode_d  = mode[win_idx];
                    hold_cnt_d     = 8'd0;
                    last_ptr_d     = win_idx;
                end
            end
            FIRE: begin
                // last_ptr_q is the current owner while in FIRE.
                if (gs_halt) begin
                    state_d        = HALT;
                    grant_d        = 3'b000;
                    fire_command_d = 1'b0;
                end else if (gs_block || !req[last_ptr_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d        = GAP;
                    grant_d        = 3'b000;
                    fire_command_d = 1'b0;
                    gap_cnt_d      = 8'd0;
                end else begin
                    hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (gs_halt) begin
                    state_d        = HALT;
                    grant_d        = 3'b000;
                    fire_command_d = 1'b0;
                end else if (gap_cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = (gap_cnt_q == 8'hFF) ? gap_cnt_q : gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d        = HALT;
                grant_d        = 3'b000;
                fire_command_d = 1'b0;
            end
        endcase

        busy_d   = (state_d != IDLE);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge sysclk or negedge reboot_n) begin
        if (!reboot_n) begin
            state_q        <= IDLE;
            grant_q        <= 3'b000;
            fire_command_q <= 1'b0;
            firing_mode_q  <= 1'b0;
            busy_q         <= 1'b0;
            halted_q       <= 1'b0;
            hold_cnt_q     <= 8'd0;
            gap_cnt_q      <= 8'd0;
            last_ptr_q     <= 2'd2;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            fire_command_q <= fire_command_d;
            firing_mode_q  <= firing_mode_d;
            busy_q         <= busy_d;
            halted_q       <= halted_d;
            hold_cnt_q     <= hold_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            last_ptr_q     <= last_ptr_d;
            armed_q        <= armed_d;
        end
    end

    assign grant        = grant_q;
    assign fire_command = fire_command_q;
    assign firing_mode  = firing_mode_q;
    assign busy         = busy_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_gun_fire_arbiter.sv
// Purpose : directed self-checking bench for gun_fire_arbiter with default parameters.
// Latency : outputs sampled 1 time unit after each rising sysclk edge.
// Backpressure: not applicable; stimulus is a fixed directed sequence.
module tb_gun_fire_arbiter;

    logic       sysclk = 1'b0;
    logic       reboot_n;
    logic [2:0] req;
    logic [2:0] mode;
    logic [2:0] gun_state;
    logic [2:0] grant;
    logic       fire_command;
    logic       firing_mode;
    logic       busy;
    logic       halted;

    int n_chk  = 0;
    int n_pass = 0;

    gun_fire_arbiter #(
        .MAX_HOLD  (16),
        .GAP_CYCLES(4)
    ) u_dut (
        .sysclk      (sysclk),
        .reboot_n    (reboot_n),
        .req         (req),
        .mode        (mode),
        .gun_state   (gun_state),
        .grant       (grant),
        .fire_command(fire_command),
        .firing_mode (firing_mode),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Leaves reboot_n released just after an edge; the next edge arms the
    // arbiter and the one after that can issue the first grant.
    task automatic do_reset();
        reboot_n = 1'b0;
        step();
        step();
        reboot_n = 1'b1;
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;

        // Reset state
        reboot_n  = 1'b0;
        req       = 3'b000;
        mode      = 3'b000;
        gun_state = 3'b000;
        #1;
        check_eq("rst_grant",  32'(grant), 32'h0);
        check_eq("rst_fire",   32'(fire_command), 32'h0);
        check_eq("rst_mode",   32'(firing_mode), 32'h0);
        check_eq("rst_busy",   32'(busy), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        step();

        // Round robin with all consoles requesting
        req = 3'b111;
        reboot_n = 1'b1;
        step();
        check_eq("first_edge_no_grant", 32'(grant), 32'h0);
        step();
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 16; c++) begin
                check_eq("rr_grant", 32'(grant), 32'(rr_exp[g]));
                check_eq("rr_fire",  32'(fire_command), 32'h1);
                step();
            end
            for (int c = 0; c < 4; c++) begin
                check_eq("rr_gap_grant", 32'(grant), 32'h0);
                check_eq("rr_gap_fire",  32'(fire_command), 32'h0);
                check_eq("rr_gap_busy",  32'(busy), (c < 3) ? 32'h1 : 32'h0);
                step();
            end
        end
        check_eq("rr_next", 32'(grant), 32'h2);

        // Single console, auto mode, mode toggling ignored, request drop
        req  = 3'b010;
        mode = 3'b010;
        do_reset();
        step();
        check_eq("c1_arm_grant", 32'(grant), 32'h0);
        step();
        check_eq("c1_grant", 32'(grant), 32'h2);
        check_eq("c1_fire",  32'(fire_command), 32'h1);
        check_eq("c1_mode",  32'(firing_mode), 32'h1);
        for (int i = 0; i < 3; i++) begin
            mode = mode ^ 3'b010;
            step();
            check_eq("c1_mode_hold", 32'(firing_mode), 32'h1);
            check_eq("c1_grant_hold", 32'(grant), 32'h2);
        end
        step();
        req = 3'b000;
        step();
        check_eq("c1_drop_grant", 32'(grant), 32'h0);
        check_eq("c1_drop_fire",  32'(fire_command), 32'h0);
        check_eq("c1_drop_busy",  32'(busy), 32'h1);

        // Overheat in FIRE, blocked in IDLE, resume after clear
        req  = 3'b111;
        mode = 3'b000;
        do_reset();
        step();
        step();
        check_eq("oh_grant", 32'(grant), 32'h1);
        check_eq("oh_mode",  32'(firing_mode), 32'h0);
        gun_state = 3'b100;
        step();
        check_eq("oh_gap_grant", 32'(grant), 32'h0);
        check_eq("oh_gap_fire",  32'(fire_command), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("oh_blocked", 32'(grant), 32'h0);
        end
        check_eq("oh_idle_busy", 32'(busy), 32'h0);
        gun_state = 3'b000;
        step();
        check_eq("oh_resume_grant", 32'(grant), 32'h2);
        check_eq("oh_resume_fire",  32'(fire_command), 32'h1);

        // Downfall in FIRE -> HALT, sticky until reset
        gun_state = 3'b101;
        step();
        check_eq("halt_flag",  32'(halted), 32'h1);
        check_eq("halt_grant", 32'(grant), 32'h0);
        check_eq("halt_fire",  32'(fire_command), 32'h0);
        check_eq("halt_busy",  32'(busy), 32'h1);
        gun_state = 3'b000;
        for (int i = 0; i < 4; i++) begin
            req = req ^ 3'b111;
            step();
            check_eq("halt_sticky", 32'(halted), 32'h1);
            check_eq("halt_sticky_grant", 32'(grant), 32'h0);
        end
        reboot_n = 1'b0;
        #1;
        check_eq("halt_rst_flag", 32'(halted), 32'h0);
        check_eq("halt_rst_busy", 32'(busy), 32'h0);

        // Reserved gun_state code acts as idle; async reset mid-FIRE
        gun_state = 3'b110;
        req       = 3'b001;
        do_reset();
        step();
        step();
        check_eq("code110_grant", 32'(grant), 32'h1);
        check_eq("code110_fire",  32'(fire_command), 32'h1);
        #3;
        reboot_n = 1'b0;
        #1;
        check_eq("async_fire",  32'(fire_command), 32'h0);
        check_eq("async_grant", 32'(grant), 32'h0);
        req       = 3'b100;
        gun_state = 3'b000;
        step();
        reboot_n = 1'b1;
        step();
        check_eq("post_rst_arm", 32'(grant), 32'h0);
        step();
        check_eq("post_rst_grant", 32'(grant), 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
